// File: rtl/prio_enc_event_queue.sv
// prio_enc_event_queue: captures rising edges on N request lines into a sticky
// pending vector and presents them one at a time, highest index first, as a
// binary code behind a valid/ready handshake.
// Optional feature: define PRIO_ENC_SYNC_EN to insert a two-flop synchroniser
// on every request line ahead of the edge detector.
module prio_enc_event_queue #(
    parameter int unsigned N       = 10,
    parameter bit          ACT_LOW = 1'b0,
    localparam int unsigned W      = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] i,
    output logic [W-1:0] o_code,
    output logic         o_valid,
    input  logic         i_ready,
    output logic         o_busy,
    output logic         o_drop
);

    typedef enum logic [0:0] {StEmpty, StFull} state_e;

    state_e       state_q, state_d;
    logic [N-1:0] pending_q, pending_d;
    logic [N-1:0] raw_q;
    logic [W-1:0] code_q, code_d;
    logic         busy_q, busy_d;
    logic         drop_q, drop_d;

    logic [N-1:0] raw_in, raw, rise, clr;
    logic [W-1:0] hi_idx;
    logic         load;

    assign raw_in = ACT_LOW ? ~i : i;

`ifdef PRIO_ENC_SYNC_EN
    logic [N-1:0] sync1_q, sync2_q;

    // Two-flop synchroniser for lines that are asynchronous to clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw_in;
            sync2_q <= sync1_q;
        end
    end

    assign raw = sync2_q;
`else
    assign raw = raw_in;
`endif

    assign rise = raw & ~raw_q;

    // Highest set index of the pending vector as it stood before this cycle's rises
    always_comb begin
        hi_idx = '0;
        for (int k = 0; k < N; k++) begin
            if (pending_q[k]) begin
                hi_idx = W'(k);
            end
        end
    end

    // Output FSM and pending-vector next state
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        load    = 1'b0;
        clr     = '0;
        unique case (state_q)
            StEmpty: begin
                if (pending_q != '0) begin
                    load    = 1'b1;
                    state_d = StFull;
                end
            end
            StFull: begin
                if (i_ready) begin
                    if (pending_q != '0) begin
                        load = 1'b1;
                    end else begin
                        state_d = StEmpty;
                    end
                end
            end
            default: state_d = StEmpty;
        endcase
        if (load) begin
            clr[hi_idx] = 1'b1;
            code_d      = hi_idx;
        end
        // A rise on the bit being cleared wins; a rise on a held bit is dropped
        pending_d = (pending_q & ~clr) | rise;
        drop_d    = |(rise & pending_q & ~clr);
        busy_d    = |pending_d;
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StEmpty;
            pending_q <= '0;
            raw_q     <= '0;
            code_q    <= '0;
            busy_q    <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            raw_q     <= raw;
            code_q    <= code_d;
            busy_q    <= busy_d;
            drop_q    <= drop_d;
        end
    end

    assign o_code  = code_q;
    assign o_valid = (state_q == StFull);
    assign o_busy  = busy_q;
    assign o_drop  = drop_q;

endmodule
